// File: rtl/fetch_arbiter.sv
// fetch_arbiter: round-robin arbiter that shares a single-port object memory
// between two burst fetch requesters.
//   clk, rst                : clock, synchronous active-high reset
//   req/base/len [0|1]      : burst request, start address, word count
//   gnt [0|1], done [0|1]   : one-cycle grant and burst-complete pulses
//   mem_rd_en/addr/rdata    : memory read port, data RD_LAT cycles after strobe
//   rd_data/valid/id/last   : returned word with owner and end-of-burst tag
//   busy, end_of_memory     : not-IDLE flag, sticky "reached LAST_ADDR" flag
module fetch_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int LAST_ADDR = 185,
  parameter int RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] base0,
  input  logic [ADDR_W-1:0] len0,
  output logic              gnt0,
  output logic              done0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] base1,
  input  logic [ADDR_W-1:0] len1,
  output logic              gnt1,
  output logic              done1,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_id,
  output logic              rd_last,
  output logic              busy,
  output logic              end_of_memory
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cur, rem;
  logic              owner, prio, degen, eom;

  // Return tags, stage RD_LAT is the one aligned with mem_rdata.
  logic [RD_LAT:1]   vld_pipe, id_pipe, last_pipe;

  logic              grant_any, grant_id, last_issue;
  logic [ADDR_W-1:0] sel_base, sel_len;

  // prio==0 favours requester 0 when both ask.
  assign grant_any  = req0 | req1;
  assign grant_id   = (req0 & req1) ? prio : req1;
  assign sel_base   = grant_id ? base1 : base0;
  assign sel_len    = grant_id ? len1  : len0;
  assign last_issue = (rem == ADDR_W'(1)) || (cur == LAST);

  assign mem_rd_en     = (state == ISSUE);
  assign mem_addr      = cur;
  assign busy          = (state != IDLE);
  assign end_of_memory = eom;
  assign rd_data       = mem_rdata;
  assign rd_valid      = vld_pipe[RD_LAT];
  assign rd_id         = id_pipe[RD_LAT];
  assign rd_last       = last_pipe[RD_LAT];

  always_comb begin
    state_nx = state;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    done0    = 1'b0;
    done1    = 1'b0;
    case (state)
      IDLE: if (grant_any) begin
        gnt0 = ~grant_id;
        gnt1 = grant_id;
        // Empty or out-of-range bursts skip ISSUE and finish from DRAIN.
        state_nx = ((sel_len == '0) || (sel_base > LAST)) ? DRAIN : ISSUE;
      end
      ISSUE: if (last_issue) state_nx = DRAIN;
      DRAIN: if (degen || (rd_valid && rd_last)) begin
        done0    = ~owner;
        done1    = owner;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      rem       <= '0;
      owner     <= 1'b0;
      prio      <= 1'b0;
      degen     <= 1'b0;
      eom       <= 1'b0;
      vld_pipe  <= '0;
      id_pipe   <= '0;
      last_pipe <= '0;
    end else begin
      state        <= state_nx;
      vld_pipe[1]  <= mem_rd_en;
      id_pipe[1]   <= owner;
      last_pipe[1] <= mem_rd_en & last_issue;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        id_pipe[i]   <= id_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
      if (state == IDLE && grant_any) begin
        owner <= grant_id;
        prio  <= ~grant_id;
        cur   <= sel_base;
        rem   <= sel_len;
        degen <= (sel_len == '0) || (sel_base > LAST);
        if (sel_base > LAST) eom <= 1'b1;
      end
      if (state == ISSUE) begin
        if (cur == LAST) eom <= 1'b1;
        // Hold cur on the final issue so it can never wrap past LAST_ADDR.
        if (!last_issue) begin
          cur <= cur + ADDR_W'(1);
          rem <= rem - ADDR_W'(1);
        end
      end
    end
  end

endmodule
